axis_mstr_arb: RTL and testbench

Upstream AXI-Stream arbiter for the user-project subsystem: merges the four user-project master streams (projects 0-3) into one stream toward the Axis-Switch. It grants round-robin, holds each grant for a whole packet (until `tlast`), and drives a registered output stage. It is the return-path counterpart of the user-project slave demux.

---
 rtl/axis_mstr_arb.sv | 199 +++++++++++++++++++
 tb/tb_axis_mstr_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_mstr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_mstr_arb                                                              |
// | Packet-locked round-robin merge of four user-project AXI-Stream masters    |
// | into one registered stream. Optional stall watchdog: AXIS_ARB_WDT_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axis_mstr_arb #(
  parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5,
  parameter int pDATA_WIDTH                  = 32,
  parameter int pWDT_CYCLES                  = 256
) (
  input  logic                                      axis_clk,
  input  logic                                      axis_rst_n,
  input  logic [3:0]                                up_tvalid,
  input  logic [4*pDATA_WIDTH-1:0]                  up_tdata,
  input  logic [7:0]                                up_tuser,
  input  logic [4*pUSER_PROJECT_SIDEBAND_WIDTH-1:0] up_tupsb,
  input  logic [4*(pDATA_WIDTH/8)-1:0]              up_tstrb,
  input  logic [4*(pDATA_WIDTH/8)-1:0]              up_tkeep,
  input  logic [3:0]                                up_tlast,
  output logic [3:0]                                up_tready,
  output logic                                      m_tvalid,
  output logic [pDATA_WIDTH-1:0]                    m_tdata,
  output logic [1:0]                                m_tuser,
  output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0]   m_tupsb,
  output logic [pDATA_WIDTH/8-1:0]                  m_tstrb,
  output logic [pDATA_WIDTH/8-1:0]                  m_tkeep,
  output logic                                      m_tlast,
  input  logic                                      m_tready,
  output logic [3:0]                                grant,
  output logic                                      wdt_err
);

  localparam int SB_W   = pUSER_PROJECT_SIDEBAND_WIDTH;
  localparam int STRB_W = pDATA_WIDTH / 8;
  localparam int BEAT_W = pDATA_WIDTH + 2 + SB_W + 2 * STRB_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic [3:0]          grant_q, grant_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [BEAT_W-1:0]   m_beat_q, m_beat_d;

  logic [BEAT_W-1:0]   sel_beat;
  logic                sel_tvalid;
  logic                sel_tlast;
  logic                out_free;
  logic                beat_acc;
  logic [1:0]          pick;
  logic                pick_found;
  logic [1:0]          scan_idx;

  // Owner's fields, flattened in output order
  always_comb begin
    sel_beat = {up_tdata[int'(owner_q)*pDATA_WIDTH +: pDATA_WIDTH],
                up_tuser[int'(owner_q)*2 +: 2],
                up_tupsb[int'(owner_q)*SB_W +: SB_W],
                up_tstrb[int'(owner_q)*STRB_W +: STRB_W],
                up_tkeep[int'(owner_q)*STRB_W +: STRB_W],
                up_tlast[owner_q]};
    sel_tvalid = up_tvalid[owner_q];
    sel_tlast  = up_tlast[owner_q];
  end

  // grant_q is zero in IDLE, so no ready can leak during arbitration
  assign out_free  = !m_tvalid_q || m_tready;
  assign up_tready = grant_q & {4{out_free}};
  assign beat_acc  = |(up_tvalid & up_tready);

  always_comb begin
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    scan_idx   = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!pick_found && up_tvalid[scan_idx]) begin
        pick       = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

`ifdef AXIS_ARB_WDT_EN
  localparam int CNT_W = (pWDT_CYCLES > 1) ? $clog2(pWDT_CYCLES) : 1;

  logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_err_q, wdt_err_d;
  logic [CNT_W-1:0] wdt_cnt_last;

  assign wdt_cnt_last = CNT_W'(pWDT_CYCLES - 1);
  assign wdt_err      = wdt_err_q;
`else
  logic wdt_unused;

  assign wdt_unused = (pWDT_CYCLES != 0);
  assign wdt_err    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
`ifdef AXIS_ARB_WDT_EN
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_PKT;
          owner_d = pick;
          grant_d = 4'b0001 << pick;
        end
      end
      ST_PKT: begin
        if (beat_acc && sel_tlast) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_q + 2'd1;
          grant_d  = 4'b0000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
`ifdef AXIS_ARB_WDT_EN
    // Only cycles with the owner not presenting data count as a stall
    if (state_q == ST_IDLE || beat_acc) begin
      wdt_cnt_d = '0;
    end else if (!sel_tvalid) begin
      if (wdt_cnt_q == wdt_cnt_last) begin
        wdt_cnt_d = '0;
        wdt_err_d = 1'b1;
        state_d   = ST_IDLE;
        rr_ptr_d  = owner_q + 2'd1;
        grant_d   = 4'b0000;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_beat_d   = m_beat_q;
    if (beat_acc) begin
      m_tvalid_d = 1'b1;
      m_beat_d   = sel_beat;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
      grant_q    <= 4'b0000;
      m_tvalid_q <= 1'b0;
      m_beat_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      m_tvalid_q <= m_tvalid_d;
      m_beat_q   <= m_beat_d;
    end
  end

`ifdef AXIS_ARB_WDT_EN
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
    end
  end
`endif

  assign grant    = grant_q;
  assign m_tvalid = m_tvalid_q;
  assign {m_tdata, m_tuser, m_tupsb, m_tstrb, m_tkeep, m_tlast} = m_beat_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_mstr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axis_mstr_arb                                                           |
// | Random-traffic bench for axis_mstr_arb with a transaction-level model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axis_mstr_arb;

  localparam int DW  = 32;
  localparam int SB  = 5;
  localparam int SW  = DW / 8;
  localparam int WDT = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    user;
    logic [SB-1:0] upsb;
    logic [SW-1:0] strb;
    logic [SW-1:0] keep;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      up_tvalid;
  logic [4*DW-1:0] up_tdata;
  logic [7:0]      up_tuser;
  logic [4*SB-1:0] up_tupsb;
  logic [4*SW-1:0] up_tstrb;
  logic [4*SW-1:0] up_tkeep;
  logic [3:0]      up_tlast;
  logic [3:0]      up_tready;
  logic            m_tvalid;
  logic [DW-1:0]   m_tdata;
  logic [1:0]      m_tuser;
  logic [SB-1:0]   m_tupsb;
  logic [SW-1:0]   m_tstrb;
  logic [SW-1:0]   m_tkeep;
  logic            m_tlast;
  logic            m_tready;
  logic [3:0]      grant;
  logic            wdt_err;
  logic [47:0]     m_beat;

  assign m_beat = {m_tdata, m_tuser, m_tupsb, m_tstrb, m_tkeep, m_tlast};

  axis_mstr_arb #(
    .pUSER_PROJECT_SIDEBAND_WIDTH(SB),
    .pDATA_WIDTH(DW),
    .pWDT_CYCLES(WDT)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .up_tvalid(up_tvalid), .up_tdata(up_tdata), .up_tuser(up_tuser),
    .up_tupsb(up_tupsb), .up_tstrb(up_tstrb), .up_tkeep(up_tkeep),
    .up_tlast(up_tlast), .up_tready(up_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tupsb(m_tupsb), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .wdt_err(wdt_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Traffic knobs (percentages)
  int pnew[4];
  int pv[4];
  int prdy;
  int lmin, lmax;
  int seq = 0;

  // Source side
  beat_t      src_q[4][$];
  logic [3:0] cur_vld;
  logic [3:0] accd;

  // Reference model: owner (-1 = idle), rotation pointer, output slot
  int    own;
  int    rr;
  bit    mv;
  int    wcnt;
  bit    werr;
  beat_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own  = -1;
    rr   = 0;
    mv   = 1'b0;
    wcnt = 0;
    werr = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    cur_vld   = 4'b0;
    accd      = 4'b0;
    up_tvalid = 4'b0;
  endtask

  task automatic gen_pkt(input int i);
    int    len;
    beat_t b;
    len = $urandom_range(lmax, lmin);
    for (int j = 0; j < len; j++) begin
      b.data = {2'(i), 30'(seq)};
      b.user = 2'($urandom);
      b.upsb = 5'($urandom);
      b.strb = 4'($urandom);
      b.keep = 4'($urandom);
      b.last = (j == len - 1);
      seq++;
      src_q[i].push_back(b);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg, er;
    eg = (own < 0) ? 4'b0 : (4'b0001 << own);
    er = (own >= 0 && (!mv || m_tready)) ? eg : 4'b0;
    check_eq("grant", 64'(grant), 64'(eg));
    check_eq("up_tready", 64'(up_tready), 64'(er));
    check_eq("m_tvalid", 64'(m_tvalid), 64'(mv));
    check_eq("wdt_err", 64'(wdt_err), 64'(werr));
    if (mv) begin
      check_eq("exp_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) check_eq("m_beat", 64'(m_beat), 64'(exp_q[0]));
    end
  endtask

  task automatic step();
    beat_t       b;
    logic [63:0] r;
    bit          acc, nwerr, rdy;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (accd[i]) void'(src_q[i].pop_front());
      if (src_q[i].size() == 0 && $urandom_range(99, 0) < pnew[i]) gen_pkt(i);
      if (src_q[i].size() == 0) cur_vld[i] = 1'b0;
      else if (!cur_vld[i] || accd[i]) cur_vld[i] = ($urandom_range(99, 0) < pv[i]);
      r = {$urandom, $urandom};
      b = r[47:0];
      if (cur_vld[i]) b = src_q[i][0];
      up_tdata[i*DW +: DW] = b.data;
      up_tuser[i*2 +: 2]   = b.user;
      up_tupsb[i*SB +: SB] = b.upsb;
      up_tstrb[i*SW +: SW] = b.strb;
      up_tkeep[i*SW +: SW] = b.keep;
      up_tlast[i]          = b.last;
    end
    accd      = 4'b0;
    up_tvalid = cur_vld;
    m_tready  = ($urandom_range(99, 0) < prdy);
    #1;
    check_outputs();

    // Advance the model by one clock
    nwerr = 1'b0;
    rdy   = !mv || m_tready;
    acc   = (own >= 0) && cur_vld[own] && rdy;
    if (mv && m_tready) void'(exp_q.pop_front());
    if (acc) begin
      accd[own] = 1'b1;
      exp_q.push_back(src_q[own][0]);
    end
    mv = acc ? 1'b1 : (mv && !m_tready);
    if (own < 0) begin
      wcnt = 0;
      for (int k = 0; k < 4; k++) begin
        if (own < 0 && cur_vld[(rr + k) % 4]) own = (rr + k) % 4;
      end
    end else if (acc && src_q[own][0].last) begin
      rr   = (own + 1) % 4;
      own  = -1;
      wcnt = 0;
    end else begin
`ifdef AXIS_ARB_WDT_EN
      if (acc) wcnt = 0;
      else if (!cur_vld[own]) begin
        wcnt++;
        if (wcnt == WDT) begin
          rr    = (own + 1) % 4;
          own   = -1;
          wcnt  = 0;
          nwerr = 1'b1;
        end
      end
`endif
    end
    werr = nwerr;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_up_tready", 64'(up_tready), 64'd0);
    check_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_m_beat", 64'(m_beat), 64'd0);
    check_eq("rst_wdt_err", 64'(wdt_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic knobs(input int pn, input int pvv, input int pr, input int lo, input int hi);
    pnew = '{pn, pn, pn, pn};
    pv   = '{pvv, pvv, pvv, pvv};
    prdy = pr;
    lmin = lo;
    lmax = hi;
  endtask

  initial begin
    rst_n    = 1'b0;
    up_tdata = '0; up_tuser = '0; up_tupsb = '0;
    up_tstrb = '0; up_tkeep = '0; up_tlast = '0;
    m_tready = 1'b0;
    model_reset();
    knobs(0, 100, 100, 1, 1);
    repeat (2) @(negedge clk);
    check_eq("init_grant", 64'(grant), 64'd0);
    check_eq("init_m_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("init_m_beat", 64'(m_beat), 64'd0);
    rst_n = 1'b1;

    // Project 1 alone after reset
    pnew[1] = 100; lmin = 1; lmax = 3;
    run(12);

    // All four streaming 2-beat packets back to back, then reset mid-packet
    knobs(100, 100, 100, 2, 2);
    run(31);
    async_reset();
    knobs(0, 100, 100, 2, 2);
    pnew[1] = 100;
    run(8);

    // Single-beat packets from projects 2 and 3
    knobs(0, 100, 100, 1, 1);
    pnew[2] = 100; pnew[3] = 100;
    run(16);

    // Packet lock with a gapped owner and a waiting competitor
    knobs(0, 60, 100, 4, 4);
    pnew[0] = 100; pnew[3] = 100;
    run(40);

    // Sustained backpressure mid-packet
    knobs(100, 100, 100, 6, 6);
    run(3);
    prdy = 0;
    run(5);
    prdy = 100;
    run(12);

    // Random mixed traffic
    knobs(30, 70, 60, 1, 5);
    run(2000);

    // Drain, then stall project 1 after its first beat while project 2 waits
    knobs(0, 100, 100, 3, 3);
    run(40);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    pnew[1] = 100;
    run(1);
    pnew[1] = 0;
    run(1);
    pv[1]   = 0;
    lmin = 2; lmax = 2;
    pnew[2] = 100;
    run(20);
    pv[1]   = 100;
    pnew[2] = 0;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
